// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared encodings for the memory request arbiter
package mem_req_arbiter_pkg;

    // Access size encodings on mem_size_i / bus_size_o
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    // Request direction on bus_req_o
    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    // Default owner IDs
    localparam logic [3:0] IF_ID_DEF  = 4'd0;
    localparam logic [3:0] MEM_ID_DEF = 4'd1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - client and AXI-master-side signal bundle
// slave modport : arbiter view (client requests and bus responses in)
// master modport: clients + AXI master view (drives requests, sees grants)
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    // IF client
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    // MEM client
    logic              mem_req_i;
    logic              mem_wen_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [1:0]        mem_size_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_gnt_o;
    logic              mem_rvalid_o;
    logic [DATA_W-1:0] mem_rdata_o;
    // AXI master side
    logic              bus_valid_o;
    logic              bus_req_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [1:0]        bus_size_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [ID_W-1:0]   bus_id_o;
    logic              bus_busy_i;
    logic [DATA_W-1:0] bus_rdata_i;
    logic [ID_W-1:0]   bus_rid_i;
    // Stall
    logic              busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  mem_req_i, mem_wen_i, mem_addr_i, mem_size_i, mem_wdata_i,
        output mem_gnt_o, mem_rvalid_o, mem_rdata_o,
        output bus_valid_o, bus_req_o, bus_addr_o, bus_size_o, bus_wdata_o, bus_id_o,
        input  bus_busy_i, bus_rdata_i, bus_rid_i,
        output busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output mem_req_i, mem_wen_i, mem_addr_i, mem_size_i, mem_wdata_i,
        input  mem_gnt_o, mem_rvalid_o, mem_rdata_o,
        input  bus_valid_o, bus_req_o, bus_addr_o, bus_size_o, bus_wdata_o, bus_id_o,
        output bus_busy_i, bus_rdata_i, bus_rid_i,
        input  busy_o
    );
endinterface

// File: rtl/mem_req_arbiter_arb_grant.sv
// rtl/mem_req_arbiter_arb_grant.sv - two-way combinational grant (IF vs MEM)
// Ports: i_en (arbiter may grant), i_if_req, i_mem_req -> o_if_gnt, o_mem_gnt.
// ARB_ROUND_ROBIN_EN: adds clock/reset and a last-winner pointer so that
// simultaneous requests alternate; otherwise MEM has fixed priority.
module arb_grant (
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clock,
    input  logic reset,
`endif
    input  logic i_en,
    input  logic i_if_req,
    input  logic i_mem_req,
    output logic o_if_gnt,
    output logic o_mem_gnt
);

    logic w_mem_first;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = IF was served last, so MEM has priority; reset leaves MEM first
    logic r_last_if;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_if <= 1'b1;
        end else if (o_if_gnt || o_mem_gnt) begin
            r_last_if <= o_if_gnt;
        end
    end

    assign w_mem_first = r_last_if;
`else
    assign w_mem_first = 1'b1;
`endif

    always_comb begin
        o_if_gnt  = 1'b0;
        o_mem_gnt = 1'b0;
        if (i_en) begin
            if (i_mem_req && (w_mem_first || !i_if_req)) begin
                o_mem_gnt = 1'b1;
            end else if (i_if_req) begin
                o_if_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - single-outstanding IF/MEM arbiter in front of the AXI master
// Ports: clock, reset (async active-low), bus (mem_req_arbiter_if.slave) carrying
// IF/MEM client requests, grants, responses, the held AXI request and busy_o.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of MEM-first.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int            ADDR_W = 32,
    parameter int            DATA_W = 64,
    parameter int            ID_W   = 4,
    parameter logic [ID_W-1:0] IF_ID  = ID_W'(IF_ID_DEF),
    parameter logic [ID_W-1:0] MEM_ID = ID_W'(MEM_ID_DEF)
) (
    input  logic               clock,
    input  logic               reset,
    mem_req_arbiter_if.slave   bus
);

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wen;
    logic [ID_W-1:0]   r_id;
    logic              r_bus_valid;
    logic              r_busy;
    logic              r_busy_d;
    logic              r_if_rvalid;
    logic              r_mem_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;

    logic w_grant_en;
    logic w_if_gnt;
    logic w_mem_gnt;
    logic w_done;

    // Grants only in IDLE, and never while reset is held
    assign w_grant_en = (r_state == ARB_IDLE) && reset;

    arb_grant u_arb_grant (
`ifdef ARB_ROUND_ROBIN_EN
        .clock     (clock),
        .reset     (reset),
`endif
        .i_en      (w_grant_en),
        .i_if_req  (bus.if_req_i),
        .i_mem_req (bus.mem_req_i),
        .o_if_gnt  (w_if_gnt),
        .o_mem_gnt (w_mem_gnt)
    );

    // Completion: busy falling edge carrying our own ID
    assign w_done = r_busy_d && !bus.bus_busy_i && (bus.bus_rid_i == r_id);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ARB_IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_wdata      <= '0;
            r_wen        <= 1'b0;
            r_id         <= '0;
            r_bus_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_busy_d     <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
        end else begin
            r_busy_d     <= bus.bus_busy_i;
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_mem_gnt) begin
                        r_addr      <= bus.mem_addr_i;
                        r_size      <= bus.mem_size_i;
                        r_wdata     <= bus.mem_wdata_i;
                        r_wen       <= bus.mem_wen_i;
                        r_id        <= MEM_ID;
                        r_bus_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ARB_ISSUE;
                    end else if (w_if_gnt) begin
                        r_addr      <= bus.if_addr_i;
                        r_size      <= SIZE_D;
                        r_wdata     <= '0;
                        r_wen       <= REQ_READ;
                        r_id        <= IF_ID;
                        r_bus_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (bus.bus_busy_i) begin
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (w_done) begin
                        r_bus_valid <= 1'b0;
                        r_state     <= ARB_RESP;
                        if (r_id == MEM_ID) begin
                            r_mem_rvalid <= 1'b1;
                            r_mem_rdata  <= (r_wen == REQ_WRITE) ? '0 : bus.bus_rdata_i;
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= bus.bus_rdata_i;
                        end
                    end
                end
                ARB_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_bus_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt_o     = w_if_gnt;
    assign bus.mem_gnt_o    = w_mem_gnt;
    assign bus.if_rvalid_o  = r_if_rvalid;
    assign bus.if_rdata_o   = r_if_rdata;
    assign bus.mem_rvalid_o = r_mem_rvalid;
    assign bus.mem_rdata_o  = r_mem_rdata;
    assign bus.bus_valid_o  = r_bus_valid;
    assign bus.bus_req_o    = r_wen;
    assign bus.bus_addr_o   = r_addr;
    assign bus.bus_size_o   = r_size;
    assign bus.bus_wdata_o  = r_wdata;
    assign bus.bus_id_o     = r_id;
    assign bus.busy_o       = r_busy;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_req_arbiter_if u_if ();

    mem_req_arbiter u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called from the ISSUE (or WAIT) negedge: busy 1 for a cycle, then 0 with rid/rdata.
    // Returns at the following negedge (RESP if the ID matched).
    task automatic complete(input logic [3:0] rid, input logic [63:0] rdata);
        u_if.bus_busy_i = 1'b1;
        @(negedge clock);
        u_if.bus_busy_i  = 1'b0;
        u_if.bus_rid_i   = rid;
        u_if.bus_rdata_i = rdata;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        u_if.if_req_i    = 1'b0;
        u_if.if_addr_i   = '0;
        u_if.mem_req_i   = 1'b0;
        u_if.mem_wen_i   = 1'b0;
        u_if.mem_addr_i  = '0;
        u_if.mem_size_i  = 2'b00;
        u_if.mem_wdata_i = '0;
        u_if.bus_busy_i  = 1'b0;
        u_if.bus_rdata_i = '0;
        u_if.bus_rid_i   = '0;

        // Reset state
        repeat (2) @(negedge clock);
        check_eq("rst_bus_valid", u_if.bus_valid_o, 0);
        check_eq("rst_busy", u_if.busy_o, 0);
        check_eq("rst_bus_addr", u_if.bus_addr_o, 0);
        check_eq("rst_rvalid", {u_if.if_rvalid_o, u_if.mem_rvalid_o}, 0);
        reset = 1'b1;

        // 1. IF-only read
        @(negedge clock);
        u_if.if_req_i  = 1'b1;
        u_if.if_addr_i = 32'h8000_0000;
        #1 check_eq("t1_if_gnt", u_if.if_gnt_o, 1);
        check_eq("t1_mem_gnt", u_if.mem_gnt_o, 0);
        @(negedge clock);
        u_if.if_req_i = 1'b0;
        check_eq("t1_bus_valid", u_if.bus_valid_o, 1);
        check_eq("t1_bus_addr", u_if.bus_addr_o, 64'h8000_0000);
        check_eq("t1_bus_req", u_if.bus_req_o, 0);
        check_eq("t1_bus_id", u_if.bus_id_o, 0);
        check_eq("t1_bus_size", u_if.bus_size_o, 3);
        check_eq("t1_busy", u_if.busy_o, 1);
        complete(4'd0, 64'h1122_3344_5566_7788);
        check_eq("t1_if_rvalid", u_if.if_rvalid_o, 1);
        check_eq("t1_if_rdata", u_if.if_rdata_o, 64'h1122_3344_5566_7788);
        check_eq("t1_mem_rvalid", u_if.mem_rvalid_o, 0);
        check_eq("t1_resp_bus_valid", u_if.bus_valid_o, 0);
        check_eq("t1_resp_busy", u_if.busy_o, 1);
        @(negedge clock);
        check_eq("t1_if_rvalid_off", u_if.if_rvalid_o, 0);
        check_eq("t1_idle_busy", u_if.busy_o, 0);
        check_eq("t1_if_rdata_hold", u_if.if_rdata_o, 64'h1122_3344_5566_7788);

        // 2. MEM write, size W
        u_if.mem_req_i   = 1'b1;
        u_if.mem_wen_i   = 1'b1;
        u_if.mem_addr_i  = 32'h8000_0104;
        u_if.mem_size_i  = 2'b10;
        u_if.mem_wdata_i = 64'hDEAD_BEEF;
        #1 check_eq("t2_mem_gnt", u_if.mem_gnt_o, 1);
        @(negedge clock);
        u_if.mem_req_i   = 1'b0;
        u_if.mem_wdata_i = 64'h0;
        u_if.mem_addr_i  = 32'h0;
        check_eq("t2_bus_req", u_if.bus_req_o, 1);
        check_eq("t2_bus_size", u_if.bus_size_o, 2);
        check_eq("t2_bus_addr", u_if.bus_addr_o, 64'h8000_0104);
        check_eq("t2_bus_wdata", u_if.bus_wdata_o, 64'hDEAD_BEEF);
        check_eq("t2_bus_id", u_if.bus_id_o, 1);
        complete(4'd1, 64'hFFFF_0000_FFFF_0000);
        check_eq("t2_mem_rvalid", u_if.mem_rvalid_o, 1);
        check_eq("t2_mem_rdata", u_if.mem_rdata_o, 0);
        check_eq("t2_if_rvalid", u_if.if_rvalid_o, 0);
        @(negedge clock);
        check_eq("t2_mem_rvalid_off", u_if.mem_rvalid_o, 0);

        // 3. Collisions
        u_if.if_req_i   = 1'b1;
        u_if.if_addr_i  = 32'h8000_0200;
        u_if.mem_req_i  = 1'b1;
        u_if.mem_wen_i  = 1'b0;
        u_if.mem_addr_i = 32'h8000_0300;
        u_if.mem_size_i = 2'b11;
        #1 check_eq("t3_c1_mem_gnt", u_if.mem_gnt_o, 1);
        check_eq("t3_c1_if_gnt", u_if.if_gnt_o, 0);
        @(negedge clock);
        u_if.mem_req_i = 1'b0;
        check_eq("t3_c1_bus_id", u_if.bus_id_o, 1);
        #1 check_eq("t3_issue_if_gnt", u_if.if_gnt_o, 0);
        complete(4'd1, 64'hAAAA_0000_0000_0001);
        check_eq("t3_c1_mem_rdata", u_if.mem_rdata_o, 64'hAAAA_0000_0000_0001);
        #1 check_eq("t3_resp_if_gnt", u_if.if_gnt_o, 0);
        @(negedge clock);
        u_if.mem_req_i = 1'b1;     // second collision, IF still waiting
        #1 check_eq("t3_c2_mem_gnt", u_if.mem_gnt_o, RR ? 0 : 1);
        check_eq("t3_c2_if_gnt", u_if.if_gnt_o, RR ? 1 : 0);
        @(negedge clock);
        if (RR) u_if.if_req_i = 1'b0;
        else    u_if.mem_req_i = 1'b0;
        check_eq("t3_c2_bus_id", u_if.bus_id_o, RR ? 0 : 1);
        complete(RR ? 4'd0 : 4'd1, 64'hBBBB);
        @(negedge clock);
        #1 check_eq("t3_c3_if_gnt", u_if.if_gnt_o, RR ? 0 : 1);
        check_eq("t3_c3_mem_gnt", u_if.mem_gnt_o, RR ? 1 : 0);
        @(negedge clock);
        u_if.if_req_i  = 1'b0;
        u_if.mem_req_i = 1'b0;
        check_eq("t3_c3_bus_id", u_if.bus_id_o, RR ? 1 : 0);
        complete(RR ? 4'd1 : 4'd0, 64'hCCCC);
        @(negedge clock);

        // 4. Mismatched rid is ignored
        u_if.if_req_i  = 1'b1;
        u_if.if_addr_i = 32'h8000_0400;
        #1 check_eq("t4_if_gnt", u_if.if_gnt_o, 1);
        @(negedge clock);
        u_if.if_req_i = 1'b0;
        complete(4'd1, 64'hBAD0_BAD0);
        check_eq("t4_stay_valid", u_if.bus_valid_o, 1);
        check_eq("t4_no_if_rvalid", u_if.if_rvalid_o, 0);
        check_eq("t4_no_mem_rvalid", u_if.mem_rvalid_o, 0);
        check_eq("t4_stay_busy", u_if.busy_o, 1);
        complete(4'd0, 64'h0123_4567_89AB_CDEF);
        check_eq("t4_if_rvalid", u_if.if_rvalid_o, 1);
        check_eq("t4_if_rdata", u_if.if_rdata_o, 64'h0123_4567_89AB_CDEF);
        @(negedge clock);

        // 5. Reset during WAIT
        u_if.if_req_i  = 1'b1;
        u_if.if_addr_i = 32'h8000_0500;
        @(negedge clock);
        u_if.bus_busy_i = 1'b1;
        @(negedge clock);
        check_eq("t5_in_wait", u_if.bus_valid_o, 1);
        #2 reset = 1'b0;
        #1 check_eq("t5_rst_bus_valid", u_if.bus_valid_o, 0);
        check_eq("t5_rst_busy", u_if.busy_o, 0);
        check_eq("t5_rst_bus_addr", u_if.bus_addr_o, 0);
        check_eq("t5_rst_if_rdata", u_if.if_rdata_o, 0);
        check_eq("t5_rst_if_gnt", u_if.if_gnt_o, 0);
        u_if.bus_busy_i = 1'b0;
        u_if.bus_rid_i  = 4'd0;
        u_if.if_req_i   = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("t5_no_rvalid_a", u_if.if_rvalid_o, 0);
        @(negedge clock);
        check_eq("t5_no_rvalid_b", u_if.if_rvalid_o, 0);
        u_if.if_req_i  = 1'b1;
        u_if.if_addr_i = 32'h8000_0600;
        #1 check_eq("t5_regrant", u_if.if_gnt_o, 1);
        @(negedge clock);
        u_if.if_req_i = 1'b0;
        check_eq("t5_bus_addr", u_if.bus_addr_o, 64'h8000_0600);
        complete(4'd0, 64'h55);
        check_eq("t5_if_rvalid", u_if.if_rvalid_o, 1);
        @(negedge clock);

        // 6. Back-to-back MEM reads, request held throughout
        u_if.mem_req_i  = 1'b1;
        u_if.mem_wen_i  = 1'b0;
        u_if.mem_addr_i = 32'h8000_0700;
        u_if.mem_size_i = 2'b11;
        #1 check_eq("t6_gnt1", u_if.mem_gnt_o, 1);
        @(negedge clock);
        check_eq("t6_issue_busy", u_if.busy_o, 1);
        #1 check_eq("t6_issue_no_gnt", u_if.mem_gnt_o, 0);
        u_if.bus_busy_i = 1'b1;
        @(negedge clock);
        check_eq("t6_wait_busy", u_if.busy_o, 1);
        u_if.bus_busy_i  = 1'b0;
        u_if.bus_rid_i   = 4'd1;
        u_if.bus_rdata_i = 64'hD1D1_D1D1;
        @(negedge clock);
        check_eq("t6_rvalid1", u_if.mem_rvalid_o, 1);
        check_eq("t6_rdata1", u_if.mem_rdata_o, 64'hD1D1_D1D1);
        check_eq("t6_resp_busy", u_if.busy_o, 1);
        #1 check_eq("t6_resp_no_gnt", u_if.mem_gnt_o, 0);
        @(negedge clock);
        u_if.mem_addr_i = 32'h8000_0708;
        #1 check_eq("t6_gnt2", u_if.mem_gnt_o, 1);
        @(negedge clock);
        u_if.mem_req_i = 1'b0;
        check_eq("t6_bus_addr2", u_if.bus_addr_o, 64'h8000_0708);
        complete(4'd1, 64'hD2D2_D2D2);
        check_eq("t6_rvalid2", u_if.mem_rvalid_o, 1);
        check_eq("t6_rdata2", u_if.mem_rdata_o, 64'hD2D2_D2D2);
        @(negedge clock);
        check_eq("t6_idle_busy", u_if.busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
